// File: rtl/sd_bd_queue_pkg.sv
// sd_bd_queue_pkg: shared SD buffer-descriptor constants, pointer type and wrap helper.
package sd_bd_queue_pkg;
    localparam int BD_CAP     = 8;
    localparam int BD_WIDTH   = 5;
    localparam int BD_EMPTY   = BD_CAP;
    localparam int READ_CYCLE = 4;
    localparam int PTR_W      = $clog2(BD_CAP);

    typedef logic [PTR_W-1:0] bd_ptr_t;

    function automatic bd_ptr_t ptr_inc(input bd_ptr_t p);
        return (p == PTR_W'(BD_CAP - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/sd_bd_ram.sv
// sd_bd_ram: simple dual-port BD store, synchronous write and synchronous read.
module sd_bd_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/sd_bd_queue.sv
// sd_bd_queue: BD queue between host writes (32-bit words) and data-master halfword reads.
// Optional sticky overflow flag bd_ovf/ovf_rst is built when SD_BD_OVF_EN is defined.
module sd_bd_queue
    import sd_bd_queue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we_m,
    input  logic [31:0]         dat_in_m,
    output logic                ack_o_m,
    output logic                new_bd,
    input  logic                re_s,
    output logic                ack_o_s,
    output logic [15:0]         dat_out_s,
    output logic [BD_WIDTH-1:0] free_bd,
`ifdef SD_BD_OVF_EN
    output logic                bd_ovf,
    input  logic                ovf_rst,
`endif
    input  logic                a_cmp
);
    logic                ack_m_q, ack_m_d, new_bd_q, new_bd_d, tog_q, tog_d, drop_q, drop_d;
    logic                ack_s_q, ack_s_d, hit_q, hit_d, hsel_q, hsel_d;
    bd_ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]          hw_q, hw_d;
    logic [BD_WIDTH-1:0] free_q, free_d, unread_q, unread_d;
    logic                wr_go, drop, commit, ram_we, rd_go, rd_last, acmp;
    logic [31:0]         rdata;
`ifdef SD_BD_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    always_comb begin
        wr_go    = we_m && !ack_m_q;
        // The drop decision is taken on word 0 and carried to word 1 of the same BD.
        drop     = tog_q ? drop_q : (free_q == '0);
        commit   = wr_go && tog_q && !drop_q;
        ram_we   = wr_go && !drop;
        rd_go    = re_s && !ack_s_q && (unread_q != '0);
        rd_last  = rd_go && (hw_q == 2'(READ_CYCLE - 1));
        acmp     = a_cmp && (free_q != BD_WIDTH'(BD_EMPTY));
        ack_m_d  = wr_go;
        new_bd_d = commit;
        tog_d    = wr_go ? !tog_q : tog_q;
        drop_d   = wr_go ? (!tog_q && drop) : drop_q;
        wptr_d   = commit ? ptr_inc(wptr_q) : wptr_q;
        free_d   = (commit && !acmp) ? free_q - 1'b1 : (acmp && !commit) ? free_q + 1'b1 : free_q;
        unread_d = (commit && !rd_last) ? unread_q + 1'b1 : (rd_last && !commit) ? unread_q - 1'b1 : unread_q;
        ack_s_d  = re_s && !ack_s_q;
        hit_d    = rd_go;
        hsel_d   = hw_q[0];
        hw_d     = rd_go ? hw_q + 2'd1 : hw_q;
        rptr_d   = rd_last ? ptr_inc(rptr_q) : rptr_q;
`ifdef SD_BD_OVF_EN
        ovf_d    = ovf_rst ? 1'b0 : (ovf_q || (wr_go && drop));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_m_q  <= 1'b0;
            new_bd_q <= 1'b0;
            tog_q    <= 1'b0;
            drop_q   <= 1'b0;
            wptr_q   <= '0;
            free_q   <= BD_WIDTH'(BD_EMPTY);
            unread_q <= '0;
            ack_s_q  <= 1'b0;
            hit_q    <= 1'b0;
            hsel_q   <= 1'b0;
            hw_q     <= '0;
            rptr_q   <= '0;
`ifdef SD_BD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            ack_m_q  <= ack_m_d;
            new_bd_q <= new_bd_d;
            tog_q    <= tog_d;
            drop_q   <= drop_d;
            wptr_q   <= wptr_d;
            free_q   <= free_d;
            unread_q <= unread_d;
            ack_s_q  <= ack_s_d;
            hit_q    <= hit_d;
            hsel_q   <= hsel_d;
            hw_q     <= hw_d;
            rptr_q   <= rptr_d;
`ifdef SD_BD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    sd_bd_ram #(.DEPTH(2 * BD_CAP), .AW(PTR_W + 1)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({wptr_q, tog_q}),
        .wdata (dat_in_m),
        .raddr ({rptr_q, hw_q[1]}),
        .rdata (rdata)
    );

    assign ack_o_m   = ack_m_q;
    assign new_bd    = new_bd_q;
    assign ack_o_s   = ack_s_q;
    assign free_bd   = free_q;
    assign dat_out_s = (ack_s_q && hit_q) ? (hsel_q ? rdata[31:16] : rdata[15:0]) : 16'h0000;
`ifdef SD_BD_OVF_EN
    assign bd_ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_sd_bd_queue.sv
// tb_sd_bd_queue: directed self-checking bench for sd_bd_queue.
module tb_sd_bd_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_m = 1'b0, re_s = 1'b0, a_cmp = 1'b0;
    logic [31:0] dat_in_m = '0;
    logic        ack_o_m, new_bd, ack_o_s;
    logic [15:0] dat_out_s;
    logic [4:0]  free_bd;
`ifdef SD_BD_OVF_EN
    logic        bd_ovf;
    logic        ovf_rst = 1'b0;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sd_bd_queue dut (
        .clk(clk), .rst(rst), .we_m(we_m), .dat_in_m(dat_in_m), .ack_o_m(ack_o_m),
        .new_bd(new_bd), .re_s(re_s), .ack_o_s(ack_o_s), .dat_out_s(dat_out_s),
        .free_bd(free_bd),
`ifdef SD_BD_OVF_EN
        .bd_ovf(bd_ovf), .ovf_rst(ovf_rst),
`endif
        .a_cmp(a_cmp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we_m = 0; re_s = 0; a_cmp = 0; rst = 0;
        step(); step();
        rst = 1;
    endtask

    task automatic wr_word(input logic [31:0] w, output logic a, output logic nb);
        we_m = 1; dat_in_m = w;
        step();
        we_m = 0;
        a = ack_o_m; nb = new_bd;
        step();
    endtask

    task automatic rd_half(output logic a, output logic [15:0] d);
        re_s = 1;
        step();
        re_s = 0;
        a = ack_o_s; d = dat_out_s;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (free_bd !== 5'd8) begin n_err++; $display("FAIL reset_free: got %0d expected 8", free_bd); end
        n_cmp++;
        if ({ack_o_m, new_bd, ack_o_s, dat_out_s} !== 19'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {ack_o_m, new_bd, ack_o_s, dat_out_s});
        end
`ifdef SD_BD_OVF_EN
        n_cmp++;
        if (bd_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", bd_ovf); end
`endif
    endtask

    task automatic test_basic();
        logic a, nb;
        logic [15:0] d;
        logic [15:0] exp [4] = '{16'h0000, 16'h1000, 16'h0200, 16'h0000};
        do_reset();
        wr_word(32'h1000_0000, a, nb);
        n_cmp++;
        if ({a, nb} !== 2'b10) begin n_err++; $display("FAIL basic_word0: got ack/new_bd %b expected 10", {a, nb}); end
        wr_word(32'h0000_0200, a, nb);
        n_cmp++;
        if ({a, nb} !== 2'b11) begin n_err++; $display("FAIL basic_word1: got ack/new_bd %b expected 11", {a, nb}); end
        n_cmp++;
        if (free_bd !== 5'd7) begin n_err++; $display("FAIL basic_free: got %0d expected 7", free_bd); end
        for (int i = 0; i < 4; i++) begin
            rd_half(a, d);
            n_cmp++;
            if ({a, d} !== {1'b1, exp[i]}) begin
                n_err++; $display("FAIL basic_read%0d: got ack %b data %h expected ack 1 data %h", i, a, d, exp[i]);
            end
        end
    endtask

    task automatic test_full_wrap();
        logic a, nb;
        logic [15:0] d;
        logic [31:0] s, c;
        logic [15:0] exp [4];
        int bad;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_word(32'hA000_0000 + i, a, nb);
            wr_word(32'hB000_0000 + i, a, nb);
        end
        n_cmp++;
        if (free_bd !== 5'd0) begin n_err++; $display("FAIL full_free: got %0d expected 0", free_bd); end
        wr_word(32'hDEAD_BEEF, a, nb);
        n_cmp++;
        if ({a, nb} !== 2'b10) begin n_err++; $display("FAIL full_drop_w0: got ack/new_bd %b expected 10", {a, nb}); end
        wr_word(32'h0000_0001, a, nb);
        n_cmp++;
        if ({a, nb} !== 2'b10) begin n_err++; $display("FAIL full_drop_w1: got ack/new_bd %b expected 10", {a, nb}); end
        n_cmp++;
        if (free_bd !== 5'd0) begin n_err++; $display("FAIL full_free_after_drop: got %0d expected 0", free_bd); end
`ifdef SD_BD_OVF_EN
        n_cmp++;
        if (bd_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", bd_ovf); end
        ovf_rst = 1; step(); ovf_rst = 0;
        n_cmp++;
        if (bd_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", bd_ovf); end
`endif
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            s = 32'hA000_0000 + i; c = 32'hB000_0000 + i;
            exp = '{s[15:0], s[31:16], c[15:0], c[31:16]};
            for (int k = 0; k < 4; k++) begin
                rd_half(a, d);
                if ({a, d} !== {1'b1, exp[k]}) begin
                    bad++; $display("FAIL full_read bd%0d hw%0d: got ack %b data %h expected ack 1 data %h", i, k, a, d, exp[k]);
                end
            end
        end
        n_cmp++;
        if (bad != 0) n_err++;
        rd_half(a, d);
        n_cmp++;
        if ({a, d} !== 17'h1_0000) begin n_err++; $display("FAIL full_9th_unreadable: got ack %b data %h expected ack 1 data 0000", a, d); end
        a_cmp = 1;
        for (int i = 0; i < 8; i++) step();
        n_cmp++;
        if (free_bd !== 5'd8) begin n_err++; $display("FAIL acmp_x8: got %0d expected 8", free_bd); end
        step();
        a_cmp = 0;
        n_cmp++;
        if (free_bd !== 5'd8) begin n_err++; $display("FAIL acmp_at_empty: got %0d expected 8", free_bd); end
        wr_word(32'h1234_5678, a, nb);
        wr_word(32'h9ABC_DEF0, a, nb);
        n_cmp++;
        if ({nb, free_bd} !== {1'b1, 5'd7}) begin n_err++; $display("FAIL wrap_commit: got new_bd %b free %0d expected 1 7", nb, free_bd); end
        exp = '{16'h5678, 16'h1234, 16'hDEF0, 16'h9ABC};
        for (int k = 0; k < 4; k++) begin
            rd_half(a, d);
            n_cmp++;
            if ({a, d} !== {1'b1, exp[k]}) begin
                n_err++; $display("FAIL wrap_read%0d: got ack %b data %h expected ack 1 data %h", k, a, d, exp[k]);
            end
        end
    endtask

    task automatic test_simul_acmp();
        logic a, nb;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_word(32'h0000_0100 * i, a, nb);
            wr_word(32'h0000_0010 + i, a, nb);
        end
        n_cmp++;
        if (free_bd !== 5'd5) begin n_err++; $display("FAIL simul_pre: got %0d expected 5", free_bd); end
        wr_word(32'h4444_0000, a, nb);
        we_m = 1; dat_in_m = 32'h0000_0044; a_cmp = 1;
        step();
        we_m = 0; a_cmp = 0;
        n_cmp++;
        if ({new_bd, free_bd} !== {1'b1, 5'd5}) begin
            n_err++; $display("FAIL simul_commit_acmp: got new_bd %b free %0d expected 1 5", new_bd, free_bd);
        end
        step();
    endtask

    task automatic test_empty_read();
        logic a, nb;
        logic [5:0] acks;
        logic       nz;
        do_reset();
        re_s = 1;
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            acks[5-i] = ack_o_s;
            if (dat_out_s !== 16'h0) nz = 1;
        end
        re_s = 0;
        step(); step();
        n_cmp++;
        if (acks !== 6'b101010) begin n_err++; $display("FAIL empty_ack_pattern: got %b expected 101010", acks); end
        n_cmp++;
        if (nz !== 1'b0) begin n_err++; $display("FAIL empty_data: got nonzero dat_out_s expected 0000"); end
        wr_word(32'hCAFE_0123, a, nb);
        we_m = 1; dat_in_m = 32'h0000_0005;
        step();
        we_m = 0;
        n_cmp++;
        if (new_bd !== 1'b1) begin n_err++; $display("FAIL latency_new_bd: got %b expected 1", new_bd); end
        re_s = 1;
        step();
        re_s = 0;
        n_cmp++;
        if ({ack_o_s, dat_out_s} !== 17'h1_0123) begin
            n_err++; $display("FAIL latency_read: got ack %b data %h expected ack 1 data 0123", ack_o_s, dat_out_s);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic a, nb;
        logic [15:0] d;
        logic [15:0] exp [3] = '{16'h2222, 16'h1111, 16'h4444};
        do_reset();
        wr_word(32'h1111_2222, a, nb);
        wr_word(32'h3333_4444, a, nb);
        for (int k = 0; k < 3; k++) begin
            rd_half(a, d);
            n_cmp++;
            if ({a, d} !== {1'b1, exp[k]}) begin
                n_err++; $display("FAIL mid_read%0d: got ack %b data %h expected ack 1 data %h", k, a, d, exp[k]);
            end
        end
        wr_word(32'hAAAA_BBBB, a, nb);
        do_reset();
        n_cmp++;
        if ({free_bd, ack_o_m, new_bd, ack_o_s, dat_out_s} !== {5'd8, 19'h0}) begin
            n_err++; $display("FAIL mid_reset_state: got free %0d outs %h expected 8 0", free_bd, {ack_o_m, new_bd, ack_o_s, dat_out_s});
        end
        wr_word(32'h5555_6666, a, nb);
        wr_word(32'h7777_8888, a, nb);
        rd_half(a, d);
        n_cmp++;
        if ({a, d} !== 17'h1_6666) begin n_err++; $display("FAIL mid_after_reset_hw0: got ack %b data %h expected ack 1 data 6666", a, d); end
        rd_half(a, d);
        n_cmp++;
        if ({a, d} !== 17'h1_5555) begin n_err++; $display("FAIL mid_after_reset_hw1: got ack %b data %h expected ack 1 data 5555", a, d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_simul_acmp();
        test_empty_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
